// File: rtl/uart_receive.sv
// uart_receive: UART receiver, 8N1 frames (8E1 when UART_RX_PARITY_EN is
// defined), LSB first. The line is oversampled at CLKS_PER_BIT clocks per
// bit and each bit is sampled at its midpoint.
//
// Optional feature macro: UART_RX_PARITY_EN (even parity bit after data).
//
// Ports:
//   clk        system clock, rising edge
//   rst        synchronous reset, active-low
//   rx         asynchronous serial line, idles high
//   data       last correctly received byte
//   sgn        one-cycle strobe: data has just been updated
//   frame_err  one-cycle strobe: stop bit sampled low
//   parity_err one-cycle strobe: parity mismatch (tied 0 without the feature)
module uart_receive #(
  parameter int CLKS_PER_BIT = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx,
  output logic [7:0] data,
  output logic       sgn,
  output logic       frame_err,
  output logic       parity_err
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);

  typedef enum logic [2:0] {
    WAIT_HIGH,
    IDLE,
    START,
    DATA,
`ifdef UART_RX_PARITY_EN
    PARITY,
`endif
    STOP
  } state_t;

  state_t          state, state_next;
  logic            sync1, rx_s;
  logic [CW-1:0]   cnt, cnt_next;
  logic [2:0]      idx, idx_next;
  logic [7:0]      shreg, shreg_next;
  logic [7:0]      data_next;
  logic            sgn_next, ferr_next;
`ifdef UART_RX_PARITY_EN
  logic            par_bit, par_bit_next;
  logic            perr, perr_next;
`endif

  // Two-flop synchronizer; resets to the idle (high) line level.
  always_ff @(posedge clk) begin
    if (!rst) begin
      sync1 <= 1'b1;
      rx_s  <= 1'b1;
    end else begin
      sync1 <= rx;
      rx_s  <= sync1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state     <= WAIT_HIGH;
      cnt       <= '0;
      idx       <= '0;
      shreg     <= '0;
      data      <= '0;
      sgn       <= 1'b0;
      frame_err <= 1'b0;
`ifdef UART_RX_PARITY_EN
      par_bit   <= 1'b0;
      perr      <= 1'b0;
`endif
    end else begin
      state     <= state_next;
      cnt       <= cnt_next;
      idx       <= idx_next;
      shreg     <= shreg_next;
      data      <= data_next;
      sgn       <= sgn_next;
      frame_err <= ferr_next;
`ifdef UART_RX_PARITY_EN
      par_bit   <= par_bit_next;
      perr      <= perr_next;
`endif
    end
  end

`ifdef UART_RX_PARITY_EN
  assign parity_err = perr;
`else
  assign parity_err = 1'b0;
`endif

  always_comb begin
    state_next = state;
    cnt_next   = '0;
    idx_next   = idx;
    shreg_next = shreg;
    data_next  = data;
    sgn_next   = 1'b0;
    ferr_next  = 1'b0;
`ifdef UART_RX_PARITY_EN
    par_bit_next = par_bit;
    perr_next    = 1'b0;
`endif

    case (state)
      WAIT_HIGH: begin
        if (rx_s) state_next = IDLE;
      end

      IDLE: begin
        if (!rx_s) state_next = START;
      end

      // Re-check the start bit at its midpoint; a high line here is a glitch.
      START: begin
        if (cnt == HALF_LAST) begin
          state_next = rx_s ? IDLE : DATA;
        end else begin
          cnt_next = cnt + CW'(1);
        end
      end

      DATA: begin
        if (cnt == BIT_LAST) begin
          shreg_next = {rx_s, shreg[7:1]};
          idx_next   = idx + 3'd1;
          if (idx == 3'd7) begin
`ifdef UART_RX_PARITY_EN
            state_next = PARITY;
`else
            state_next = STOP;
`endif
          end
        end else begin
          cnt_next = cnt + CW'(1);
        end
      end

`ifdef UART_RX_PARITY_EN
      PARITY: begin
        if (cnt == BIT_LAST) begin
          par_bit_next = rx_s;
          state_next   = STOP;
        end else begin
          cnt_next = cnt + CW'(1);
        end
      end
`endif

      // A low stop bit wins over a parity mismatch; after a framing error
      // the line must return high before a new start bit is trusted.
      STOP: begin
        if (cnt == BIT_LAST) begin
          if (!rx_s) begin
            ferr_next  = 1'b1;
            state_next = WAIT_HIGH;
          end
`ifdef UART_RX_PARITY_EN
          else if ((^shreg) ^ par_bit) begin
            perr_next  = 1'b1;
            state_next = IDLE;
          end
`endif
          else begin
            data_next  = shreg;
            sgn_next   = 1'b1;
            state_next = IDLE;
          end
        end else begin
          cnt_next = cnt + CW'(1);
        end
      end

      default: state_next = WAIT_HIGH;
    endcase
  end

endmodule

// File: tb/tb_uart_receive.sv
// tb_uart_receive: directed bench for uart_receive at 16 clocks per bit.
// Frames are driven bit by bit; a negedge monitor logs every strobe with its
// cycle number so arrival times can be compared against t0 + latency.
module tb_uart_receive;

  localparam int CPB = 16;
`ifdef UART_RX_PARITY_EN
  localparam int NB = 11;
`else
  localparam int NB = 10;
`endif
  localparam int LAT = 2 + CPB / 2 + (NB - 1) * CPB;

  logic       clk;
  logic       rst;
  logic       rx;
  logic [7:0] data;
  logic       sgn;
  logic       frame_err;
  logic       parity_err;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  int n_sgn  = 0;
  int n_ferr = 0;
  int n_perr = 0;
  int viol   = 0;
  int sgn_cyc [16];
  logic [7:0] sgn_dat [16];
  int ferr_cyc = 0;
  int perr_cyc = 0;
  logic       prev_sgn = 1'b0, prev_ferr = 1'b0, prev_perr = 1'b0;
  logic [7:0] prev_data = '0;

  uart_receive #(.CLKS_PER_BIT(CPB)) dut (
    .clk       (clk),
    .rst       (rst),
    .rx        (rx),
    .data      (data),
    .sgn       (sgn),
    .frame_err (frame_err),
    .parity_err(parity_err)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc = cyc + 1;

  always @(negedge clk) begin
    if (sgn) begin
      if (n_sgn < 16) begin
        sgn_cyc[n_sgn] = cyc;
        sgn_dat[n_sgn] = data;
      end
      n_sgn = n_sgn + 1;
    end
    if (frame_err) begin
      ferr_cyc = cyc;
      n_ferr   = n_ferr + 1;
    end
    if (parity_err) begin
      perr_cyc = cyc;
      n_perr   = n_perr + 1;
    end
    if (int'(sgn) + int'(frame_err) + int'(parity_err) > 1) viol = viol + 1;
    if ((sgn && prev_sgn) || (frame_err && prev_ferr) || (parity_err && prev_perr))
      viol = viol + 1;
    if (rst && !sgn && data !== prev_data) viol = viol + 1;
    prev_sgn  = sgn;
    prev_ferr = frame_err;
    prev_perr = parity_err;
    prev_data = data;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks = checks + 1;
    if (got !== exp) begin
      errors = errors + 1;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // All drivers start and end 1 time unit after a rising edge.
  task automatic drive_bit(input logic v);
    rx = v;
    repeat (CPB) @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    rx = 1'b1;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_frame(input logic [7:0] b, input logic stop, input logic par_good,
                            output int t0);
    t0 = cyc + 1;
    drive_bit(1'b0);
    for (int i = 0; i < 8; i++) drive_bit(b[i]);
`ifdef UART_RX_PARITY_EN
    drive_bit((^b) ^ ~par_good);
`endif
    drive_bit(stop);
  endtask

  int t0, t1, bs, bf, bp;

  initial begin
    rst = 1'b0;
    rx  = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    check("rst_data", 32'(data), 32'h00);
    check("rst_sgn", 32'(sgn), 0);
    check("rst_ferr", 32'(frame_err), 0);
    check("rst_perr", 32'(parity_err), 0);
    rst = 1'b1;
    idle(20);

    // Single frame 0xA5
    bs = n_sgn; bf = n_ferr;
    send_frame(8'hA5, 1'b1, 1'b1, t0);
    idle(30);
    check("a5_count", 32'(n_sgn - bs), 1);
    check("a5_time", 32'(sgn_cyc[bs]), 32'(t0 + LAT));
    check("a5_data", 32'(sgn_dat[bs]), 32'hA5);
    check("a5_hold", 32'(data), 32'hA5);
    check("a5_ferr", 32'(n_ferr - bf), 0);

    // Back-to-back 0x00 then 0xFF
    bs = n_sgn;
    send_frame(8'h00, 1'b1, 1'b1, t0);
    send_frame(8'hFF, 1'b1, 1'b1, t1);
    idle(30);
    check("b2b_count", 32'(n_sgn - bs), 2);
    check("b2b_t0", 32'(sgn_cyc[bs]), 32'(t0 + LAT));
    check("b2b_d0", 32'(sgn_dat[bs]), 32'h00);
    check("b2b_gap", 32'(sgn_cyc[bs + 1] - sgn_cyc[bs]), 32'(NB * CPB));
    check("b2b_d1", 32'(sgn_dat[bs + 1]), 32'hFF);

    // 4-cycle glitch, then 0x3C
    bs = n_sgn; bf = n_ferr;
    rx = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    idle(40);
    check("glitch_sgn", 32'(n_sgn - bs), 0);
    check("glitch_ferr", 32'(n_ferr - bf), 0);
    send_frame(8'h3C, 1'b1, 1'b1, t0);
    idle(30);
    check("3c_count", 32'(n_sgn - bs), 1);
    check("3c_time", 32'(sgn_cyc[bs]), 32'(t0 + LAT));
    check("3c_data", 32'(data), 32'h3C);

    // 0x55 with low stop bit, line low 40 more cycles, then 0x81
    bs = n_sgn; bf = n_ferr;
    send_frame(8'h55, 1'b0, 1'b1, t0);
    rx = 1'b0;
    repeat (40) @(posedge clk);
    #1;
    idle(40);
    check("fe_count", 32'(n_ferr - bf), 1);
    check("fe_time", 32'(ferr_cyc), 32'(t0 + LAT));
    check("fe_sgn", 32'(n_sgn - bs), 0);
    check("fe_data", 32'(data), 32'h3C);
    send_frame(8'h81, 1'b1, 1'b1, t0);
    idle(30);
    check("81_time", 32'(sgn_cyc[bs]), 32'(t0 + LAT));
    check("81_data", 32'(data), 32'h81);

    // Reset during data bit 4 of 0x99; the shared reset also idles the sender
    bs = n_sgn; bf = n_ferr; bp = n_perr;
    drive_bit(1'b0);
    drive_bit(1'b1);
    drive_bit(1'b0);
    drive_bit(1'b0);
    drive_bit(1'b1);
    rx = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("mrst_data", 32'(data), 32'h00);
    check("mrst_sgn", 32'(sgn), 0);
    check("mrst_ferr", 32'(frame_err), 0);
    check("mrst_perr", 32'(parity_err), 0);
    rst = 1'b1;
    idle(200);
    check("mrst_nostrobe", 32'((n_sgn - bs) + (n_ferr - bf) + (n_perr - bp)), 0);
    check("mrst_after", 32'(data), 32'h00);
    send_frame(8'h42, 1'b1, 1'b1, t0);
    idle(30);
    check("42_time", 32'(sgn_cyc[bs]), 32'(t0 + LAT));
    check("42_data", 32'(data), 32'h42);

`ifdef UART_RX_PARITY_EN
    // 0x07 with correct parity (1), then with wrong parity (0)
    bs = n_sgn; bp = n_perr;
    send_frame(8'h07, 1'b1, 1'b1, t0);
    idle(30);
    check("par_ok_time", 32'(sgn_cyc[bs]), 32'(t0 + 170));
    check("par_ok_data", 32'(data), 32'h07);
    send_frame(8'h07, 1'b1, 1'b0, t0);
    idle(30);
    check("par_bad_count", 32'(n_perr - bp), 1);
    check("par_bad_time", 32'(perr_cyc), 32'(t0 + 170));
    check("par_bad_sgn", 32'(n_sgn - bs), 1);
    check("par_bad_data", 32'(data), 32'h07);
`endif

    check("strobe_rules", 32'(viol), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
